sudoku_load_ctrl: RTL and testbench
===================================

Name: sudoku_load_ctrl

Overview:
- Sequencer in front of the 81-cell Sudoku board checker.
- Accepts recognised digits one per cell from the handwriting front end over a valid/ready handshake and encodes each into the checker's 11-bit cell format.
- Streams the cells into the checker's start/data port, waits for its done, then presents a held pass/fail result to the display logic until acknowledged.
- Re-arms the checker between boards and flags timeout and out-of-range digits.

Parameters:
- CELLS, 81: cells per board; the cell counter width is 7.
- DIGIT_W, 4: width of the incoming digit code.
- TIMEOUT_CYCLES, 16: WAIT_DONE cycles allowed before a timeout error.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- go  in  1  start a new board; sampled only in IDLE.
- cell_valid  in  1  front end has a digit.
- cell_digit  in  DIGIT_W  0 = empty, 1..9 = digit, 10..15 = illegal.
- cell_ready  out  1  controller accepts a cell this cycle.
- cell_idx  out  7  index of the next cell to accept, 0..80.
- sol_start  out  1  checker start/write strobe (registered).
- sol_data  out  11  checker cell word (registered).
- sol_valid  in  1  checker board-valid.
- sol_done  in  1  checker finished.
- res_valid  out  1  result available, held until ack.
- res_ok  out  1  board legal and no error.
- res_err  out  1  timeout or illegal digit seen.
- res_ack  in  1  consumer takes the result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE; cell_cnt=0; wait_cnt=0; need_kick=0; bad=0. Outputs cell_ready, sol_start, res_valid, res_ok, res_err, busy = 0; sol_data = 11'h400.
- Encoding:
  - digit d in 1..9 → bit10=0, bits[9:0] = one-hot (1<<(d-1)).
  - 0 → 11'h400 (bit10 = empty, value 0).
  - 10..15 → 11'h400 and set sticky bad.
- States:
  - IDLE: on go=1 → KICK if need_kick, else LOAD. Clear cell_cnt, wait_cnt, bad.
  - KICK: one cycle; drives sol_start=1, sol_data=11'h400 to move the checker from Finish back to Read without a write; clear need_kick; → LOAD.
  - LOAD: cell_ready=1. Acceptance = cell_valid & cell_ready. On acceptance, the next cycle has sol_start=1 with the encoded word; otherwise sol_start=0 and the checker holds. cell_cnt increments per acceptance. Acceptance at cell_cnt=80 → WAIT_DONE; cell_ready is 0 from the following cycle.
  - WAIT_DONE: wait_cnt increments each cycle.
    - sol_done is ignored on the first cycle, which carries the final write.
    - sol_done=1 with wait_cnt≥1 → capture res_ok = sol_valid & ~bad, res_err = bad; set need_kick=1; → RESULT.
    - wait_cnt reaching TIMEOUT_CYCLES → res_ok=0, res_err=1, need_kick unchanged; → RESULT.
  - RESULT: res_valid=1 and res_ok/res_err held stable. res_ack=1 → IDLE, res_valid=0 next cycle.
- Latency and throughput:
  - Last accepted cell to res_valid is 3 cycles with a conforming checker.
  - Throughput is 1 cell per cycle; an ungated source loads a board in 81 cycles (+1 if KICK).
- Boundary conditions:
  - go outside IDLE is ignored; go in the same cycle as res_ack is ignored.
  - Front-end stalls are unbounded in LOAD; there is no timeout there.
  - cell_idx = cell_cnt and holds at 80 after the last acceptance until IDLE clears it.
  - reset mid-LOAD drops the partial board and clears need_kick. The checker is reset by the same system reset, so the two stay aligned.

Decomposition:
- Shared package sudoku_pkg holds:
  - the state enum (IDLE, KICK, LOAD, WAIT_DONE, RESULT);
  - CELLS, CELL_W=11 and EMPTY_CELL=11'h400;
  - the digit-to-cell encode function.
- One sub-module, sudoku_cell_encoder: combinational digit → {cell word, illegal flag}, instantiated on the accept path.

Test Plan:
- Reset, go, 81 legal cells of a solved grid with no stalls → 81 sol_start pulses, cell_ready low after the 81st accept, res_valid=1, res_ok=1, res_err=0 3 cycles later; ack → IDLE, busy=0.
- Second board after the first, with duplicate 5s in row 0 → exactly one KICK pulse with sol_data=11'h400 before the first cell, then res_ok=0, res_err=0.
- Random cell_valid gaps (~50%) on a blank board (all 0) → sol_start only in the cycle after each accept, sol_data=11'h400 each time, res_ok=1.
- Digit 12 at cell 40 in an otherwise legal board → cell 40 written as 11'h400, res_err=1, res_ok=0.
- Checker model with sol_done stuck 0 → res_valid after 16 WAIT_DONE cycles, res_err=1, and the next go does not KICK.
- reset asserted at cell_cnt=30 → all outputs zero immediately; after release, go plus 81 cells yields a correct result with no KICK.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared types, sizes and the digit-to-cell encoding for the Sudoku load sequencer.
package sudoku_pkg;

  localparam int CELLS          = 81;
  localparam int CELL_W         = 11;
  localparam int DIGIT_W        = 4;
  localparam int CNT_W          = 7;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int WAIT_W         = 5;

  localparam logic [CELL_W-1:0] EMPTY_CELL = 11'h400;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    LOAD,
    WAIT_DONE,
    RESULT
  } state_t;

  typedef struct packed {
    logic              illegal;
    logic [CELL_W-1:0] word;
  } cell_enc_t;

  // Codes 10..15 are written as an empty cell; the caller latches the illegal flag.
  function automatic cell_enc_t encode_cell(input logic [DIGIT_W-1:0] digit);
    cell_enc_t enc;
    enc.word    = EMPTY_CELL;
    enc.illegal = 1'b0;
    if (digit >= 4'd1 && digit <= 4'd9) begin
      enc.word = CELL_W'(1) << (digit - 4'd1);
    end else if (digit > 4'd9) begin
      enc.illegal = 1'b1;
    end
    return enc;
  endfunction

endpackage

// File: rtl/sudoku_load_ctrl_if.sv
// Front-end, checker and result signals of the load sequencer, bundled with
// a controller-side (master) and environment-side (slave) view.
interface sudoku_load_ctrl_if;

  logic                            go;
  logic                            cell_valid;
  logic [sudoku_pkg::DIGIT_W-1:0]  cell_digit;
  logic                            cell_ready;
  logic [sudoku_pkg::CNT_W-1:0]    cell_idx;
  logic                            sol_start;
  logic [sudoku_pkg::CELL_W-1:0]   sol_data;
  logic                            sol_valid;
  logic                            sol_done;
  logic                            res_valid;
  logic                            res_ok;
  logic                            res_err;
  logic                            res_ack;
  logic                            busy;

  modport master (
    input  go, cell_valid, cell_digit, sol_valid, sol_done, res_ack,
    output cell_ready, cell_idx, sol_start, sol_data, res_valid, res_ok, res_err, busy
  );

  modport slave (
    output go, cell_valid, cell_digit, sol_valid, sol_done, res_ack,
    input  cell_ready, cell_idx, sol_start, sol_data, res_valid, res_ok, res_err, busy
  );

endinterface

// File: rtl/sudoku_cell_encoder.sv
// Combinational digit code to checker cell word, with an illegal-code flag.
module sudoku_cell_encoder
  import sudoku_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [CELL_W-1:0]  o_word,
  output logic               o_illegal
);

  cell_enc_t w_enc;

  assign w_enc     = encode_cell(i_digit);
  assign o_word    = w_enc.word;
  assign o_illegal = w_enc.illegal;

endmodule

// File: rtl/sudoku_load_ctrl.sv
// Streams 81 encoded cells into the board checker, waits for its verdict and
// holds a pass/fail result until acknowledged; re-arms the checker between boards.
module sudoku_load_ctrl
  import sudoku_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  sudoku_load_ctrl_if.master    bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cell_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_need_kick;
  logic               r_bad;
  logic               r_cell_ready;
  logic               r_sol_start;
  logic [CELL_W-1:0]  r_sol_data;
  logic               r_res_valid;
  logic               r_res_ok;
  logic               r_res_err;
  logic               r_busy;

  logic [CELL_W-1:0]  w_word;
  logic               w_illegal;
  logic               w_accept;

  sudoku_cell_encoder u_enc (
    .i_digit   (bus.cell_digit),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_accept = bus.cell_valid & r_cell_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cell_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_need_kick  <= 1'b0;
      r_bad        <= 1'b0;
      r_cell_ready <= 1'b0;
      r_sol_start  <= 1'b0;
      r_sol_data   <= EMPTY_CELL;
      r_res_valid  <= 1'b0;
      r_res_ok     <= 1'b0;
      r_res_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.go) begin
            r_cell_cnt <= '0;
            r_wait_cnt <= '0;
            r_bad      <= 1'b0;
            r_busy     <= 1'b1;
            // A checker parked in Finish needs one empty strobe to return to Read.
            if (r_need_kick) begin
              r_state     <= KICK;
              r_sol_start <= 1'b1;
              r_sol_data  <= EMPTY_CELL;
            end else begin
              r_state      <= LOAD;
              r_cell_ready <= 1'b1;
            end
          end
        end

        KICK: begin
          r_sol_start  <= 1'b0;
          r_need_kick  <= 1'b0;
          r_cell_ready <= 1'b1;
          r_state      <= LOAD;
        end

        LOAD: begin
          r_sol_start <= w_accept;
          if (w_accept) begin
            r_sol_data <= w_word;
            r_bad      <= r_bad | w_illegal;
            if (r_cell_cnt == CNT_W'(CELLS - 1)) begin
              r_cell_ready <= 1'b0;
              r_state      <= WAIT_DONE;
            end else begin
              r_cell_cnt <= r_cell_cnt + 7'd1;
            end
          end
        end

        WAIT_DONE: begin
          r_sol_start <= 1'b0;
          r_wait_cnt  <= r_wait_cnt + 5'd1;
          // The first cycle here still carries the final write, so done is not trusted yet.
          if (bus.sol_done && r_wait_cnt != '0) begin
            r_res_ok    <= bus.sol_valid & ~r_bad;
            r_res_err   <= r_bad;
            r_res_valid <= 1'b1;
            r_need_kick <= 1'b1;
            r_state     <= RESULT;
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            r_res_ok    <= 1'b0;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= RESULT;
          end
        end

        RESULT: begin
          if (bus.res_ack) begin
            r_res_valid <= 1'b0;
            r_res_ok    <= 1'b0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cell_ready = r_cell_ready;
  assign bus.cell_idx   = r_cell_cnt;
  assign bus.sol_start  = r_sol_start;
  assign bus.sol_data   = r_sol_data;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_ok     = r_res_ok;
  assign bus.res_err    = r_res_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_sudoku_load_ctrl.sv
// Randomised board loads against a behavioural checker and a grid-level result model.
module tb_sudoku_load_ctrl;
  import sudoku_pkg::*;

  typedef int grid_t [81];

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  sudoku_load_ctrl_if bus ();

  sudoku_load_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_need_kick = 0;
  bit stuck_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int word_to_digit(input logic [10:0] w);
    if (w == 11'h400) return 0;
    for (int i = 0; i < 9; i++) begin
      if (w == (11'(1) << i)) return i + 1;
    end
    return -1;
  endfunction

  // Values outside 1..9 are treated as empty; negative marks a malformed word.
  function automatic bit grid_legal(input grid_t g);
    bit sr [10];
    bit sc [10];
    bit sb [10];
    int vr, vc, vb;
    for (int u = 0; u < 9; u++) begin
      for (int v = 0; v < 10; v++) begin
        sr[v] = 0; sc[v] = 0; sb[v] = 0;
      end
      for (int k = 0; k < 9; k++) begin
        vr = g[u*9 + k];
        vc = g[k*9 + u];
        vb = g[(u/3)*27 + (u%3)*3 + (k/3)*9 + (k%3)];
        if (vr < 0 || vc < 0 || vb < 0) return 0;
        if (vr >= 1 && vr <= 9) begin if (sr[vr]) return 0; sr[vr] = 1; end
        if (vc >= 1 && vc <= 9) begin if (sc[vc]) return 0; sc[vc] = 1; end
        if (vb >= 1 && vb <= 9) begin if (sb[vb]) return 0; sb[vb] = 1; end
      end
    end
    return 1;
  endfunction

  function automatic bit final_legal(input grid_t g, input int last);
    g[80] = last;
    return grid_legal(g);
  endfunction

  function automatic logic [10:0] exp_word(input int d);
    if (d >= 1 && d <= 9) return 11'(1) << (d - 1);
    return 11'h400;
  endfunction

  // Checker model: Read collects 81 writes, Finish holds done until a strobe re-arms it.
  grid_t chk_grid;
  int    chk_cnt;
  bit    chk_fin;
  logic  chk_done;
  logic  chk_valid;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_cnt   <= 0;
      chk_fin   <= 0;
      chk_done  <= 1'b0;
      chk_valid <= 1'b0;
    end else if (bus.sol_start) begin
      if (chk_fin) begin
        chk_fin  <= 0;
        chk_cnt  <= 0;
        chk_done <= 1'b0;
      end else if (chk_cnt < 81) begin
        chk_grid[chk_cnt] <= word_to_digit(bus.sol_data);
        chk_cnt <= chk_cnt + 1;
        if (chk_cnt == 80) begin
          chk_fin   <= 1;
          chk_done  <= !stuck_done;
          chk_valid <= final_legal(chk_grid, word_to_digit(bus.sol_data));
        end
      end
    end
  end

  assign bus.sol_done  = chk_done;
  assign bus.sol_valid = chk_valid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic grid_t solved_grid();
    grid_t g;
    int perm [9];
    int j, t;
    for (int i = 0; i < 9; i++) perm[i] = i + 1;
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[r*9 + c] = perm[(r*3 + r/3 + c) % 9];
    return g;
  endfunction

  task automatic run_board(input grid_t g, input int gap, input bit stuck,
                           input int ncells, input string name);
    int idx = 0, pulses = 0, kicks = 0, writes = 0, since = -1, lat = -1, budget = 0;
    int hold;
    bit exp_kick, accepted, anybad, exp_ok, exp_err;
    exp_kick   = (exp_need_kick != 0);
    stuck_done = stuck;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    while (budget < 2000) begin
      if (bus.sol_start) begin
        if (exp_kick && kicks == 0 && writes == 0) begin
          check_eq({name, " kick_data"}, 32'(bus.sol_data), 32'h400);
          check_eq({name, " kick_ready"}, 32'(bus.cell_ready), 0);
          kicks++;
        end else begin
          if (writes < 81) check_eq({name, " write_data"}, 32'(bus.sol_data), 32'(exp_word(g[writes])));
          writes++;
        end
        pulses++;
      end
      if (since == 1) begin
        check_eq({name, " ready_after_last"}, 32'(bus.cell_ready), 0);
        check_eq({name, " idx_hold"}, 32'(bus.cell_idx), 80);
      end
      if (bus.res_valid) begin
        lat = since;
        break;
      end
      if (ncells < 81 && idx == ncells) break;
      if (idx < ncells && $urandom_range(99) >= 32'(gap)) begin
        bus.cell_valid = 1'b1;
        bus.cell_digit = 4'(g[idx]);
      end else begin
        bus.cell_valid = 1'b0;
        bus.cell_digit = 4'($urandom);
      end
      bus.go = ($urandom_range(7) == 0);
      accepted = bus.cell_valid && bus.cell_ready;
      if (accepted) check_eq({name, " cell_idx"}, 32'(bus.cell_idx), 32'(idx));
      step();
      budget++;
      if (since >= 0) since++;
      if (accepted) begin
        idx++;
        if (idx == 81) since = 1;
      end
    end
    bus.cell_valid = 1'b0;
    bus.go         = 1'b0;
    check_eq({name, " kicks"}, 32'(kicks), 32'(exp_kick));
    if (exp_kick) exp_need_kick = 0;
    if (ncells < 81) begin
      check_eq({name, " partial_idx"}, 32'(bus.cell_idx), 32'(ncells));
      $display("[TB] board %s partial cells=%0d writes=%0d", name, idx, writes);
      return;
    end
    anybad = 0;
    for (int i = 0; i < 81; i++) if (g[i] > 9) anybad = 1;
    exp_err = stuck || anybad;
    exp_ok  = !stuck && !anybad && grid_legal(g);
    check_eq({name, " latency"}, 32'(lat), stuck ? 32'd17 : 32'd3);
    check_eq({name, " pulses"}, 32'(pulses), 32'(81 + int'(exp_kick)));
    check_eq({name, " res_ok"}, 32'(bus.res_ok), 32'(exp_ok));
    check_eq({name, " res_err"}, 32'(bus.res_err), 32'(exp_err));
    check_eq({name, " busy_result"}, 32'(bus.busy), 1);
    hold = $urandom_range(3, 1);
    repeat (hold) begin
      step();
      check_eq({name, " hold_valid"}, 32'(bus.res_valid), 1);
      check_eq({name, " hold_ok"}, 32'(bus.res_ok), 32'(exp_ok));
    end
    bus.res_ack = 1'b1;
    bus.go      = 1'b1;
    step();
    bus.res_ack = 1'b0;
    bus.go      = 1'b0;
    check_eq({name, " ack_valid"}, 32'(bus.res_valid), 0);
    check_eq({name, " ack_busy"}, 32'(bus.busy), 0);
    step();
    check_eq({name, " go_with_ack_ignored"}, 32'(bus.busy), 0);
    if (!stuck) exp_need_kick = 1;
    $display("[TB] board %s lat=%0d ok=%0d err=%0d kicks=%0d", name, lat, exp_ok, exp_err, kicks);
  endtask

  grid_t g;

  initial begin
    bus.go         = 1'b0;
    bus.cell_valid = 1'b0;
    bus.cell_digit = '0;
    bus.res_ack    = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_eq("rst busy", 32'(bus.busy), 0);
    check_eq("rst cell_ready", 32'(bus.cell_ready), 0);
    check_eq("rst sol_start", 32'(bus.sol_start), 0);
    check_eq("rst sol_data", 32'(bus.sol_data), 32'h400);
    check_eq("rst res_valid", 32'(bus.res_valid), 0);
    @(negedge clk) reset = 1'b1;
    step();

    g = solved_grid();
    run_board(g, 0, 0, 81, "solved");

    g = solved_grid();
    for (int c = 1; c < 9; c++) if (g[c] != 5) begin g[c] = 5; break; end
    if (g[0] != 5) g[0] = 5;
    run_board(g, 10, 0, 81, "dup5");

    for (int i = 0; i < 81; i++) g[i] = 0;
    run_board(g, 50, 0, 81, "blank");

    g = solved_grid();
    g[40] = 12;
    run_board(g, 20, 0, 81, "illegal12");

    g = solved_grid();
    run_board(g, 0, 1, 81, "stuck_done");

    g = solved_grid();
    run_board(g, 0, 0, 30, "reset_mid");
    #2 reset = 1'b0;
    #1;
    check_eq("async busy", 32'(bus.busy), 0);
    check_eq("async cell_ready", 32'(bus.cell_ready), 0);
    check_eq("async sol_start", 32'(bus.sol_start), 0);
    check_eq("async sol_data", 32'(bus.sol_data), 32'h400);
    check_eq("async cell_idx", 32'(bus.cell_idx), 0);
    check_eq("async res", 32'({bus.res_valid, bus.res_ok, bus.res_err}), 0);
    exp_need_kick = 0;
    @(negedge clk) reset = 1'b1;
    step();

    g = solved_grid();
    run_board(g, 20, 0, 81, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
